// File: rtl/mmio_queue_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_queue_port: p18240 memory-bus target with an input FIFO popped by    |
// | DATA reads, an output holding register loaded by DATA writes, and STATUS. |
// | Optional IRQEN register and irq output enabled by MMIO_QUEUE_IRQ_EN.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mmio_queue_port #(
  parameter logic [15:0] BASE_ADDR = 16'h2010,
  parameter int          DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ack
`ifdef MMIO_QUEUE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int          PW            = $clog2(DEPTH);
  localparam int          CW            = PW + 1;
  localparam logic [15:0] c_STATUS_ADDR = BASE_ADDR + 16'd1;

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_out_data;
  logic          r_out_valid;
  logic          r_underflow;
  logic          r_drop;

  logic          w_selD;
  logic          w_selS;
  logic          w_rd;
  logic          w_wr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_uflow_set;
  logic          w_out_accept;
  logic          w_drop_set;
  logic          w_drive;
  logic [15:0]   w_rdata;
  logic [15:0]   w_status;

  assign w_selD  = (memAddr == BASE_ADDR);
  assign w_selS  = (memAddr == c_STATUS_ADDR);
  // Both strobes low counts as a write, so the bus is never driven then.
  assign w_rd    = !re_L && we_L;
  assign w_wr    = !we_L;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  assign w_pop        = w_rd && w_selD && !w_empty;
  assign w_push       = in_valid && !w_full;
  assign w_uflow_set  = w_rd && w_selD && w_empty;
  assign w_out_accept = w_wr && w_selD && (!r_out_valid || out_ack);
  assign w_drop_set   = w_wr && w_selD && r_out_valid && !out_ack;

  assign w_status = {3'b000, r_drop, r_underflow, r_out_valid, w_full, w_empty, 8'(r_count)};

`ifdef MMIO_QUEUE_IRQ_EN
  localparam logic [15:0] c_IRQEN_ADDR = BASE_ADDR + 16'd2;
  logic       w_selI;
  logic [1:0] r_irqen;
  logic       r_irq;

  assign w_selI = (memAddr == c_IRQEN_ADDR);
  assign irq    = r_irq;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_irqen <= 2'b00;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && w_selI) r_irqen <= dataBus[1:0];
      r_irq <= (r_irqen[0] && !w_empty) || (r_irqen[1] && !r_out_valid);
    end
  end
`endif

  always_comb begin
    w_drive = 1'b0;
    w_rdata = 16'h0000;
    if (w_rd) begin
      if (w_selD) begin
        w_drive = 1'b1;
        w_rdata = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
      end else if (w_selS) begin
        w_drive = 1'b1;
        w_rdata = w_status;
      end
`ifdef MMIO_QUEUE_IRQ_EN
      else if (w_selI) begin
        w_drive = 1'b1;
        w_rdata = {14'h0000, r_irqen};
      end
`endif
    end
  end

  assign dataBus   = w_drive ? w_rdata : 16'bz;
  assign in_ready  = !w_full;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_out_data  <= 16'h0000;
      r_out_valid <= 1'b0;
    end else if (w_out_accept) begin
      r_out_data  <= dataBus;
      r_out_valid <= 1'b1;
    end else if (out_ack && r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event in the same cycle beats a write-1-to-clear.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_underflow <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      if (w_uflow_set)                          r_underflow <= 1'b1;
      else if (w_wr && w_selS && dataBus[11])   r_underflow <= 1'b0;
      if (w_drop_set)                           r_drop      <= 1'b1;
      else if (w_wr && w_selS && dataBus[12])   r_drop      <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_queue_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mmio_queue_port: directed and randomized checks of mmio_queue_port     |
// | against a queue-based reference model.                                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mmio_queue_port;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DA    = 16'h2010;
  localparam logic [15:0] SA    = 16'h2011;
  localparam logic [15:0] IA    = 16'h2012;

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic [15:0] memAddr = 16'h0000;
  logic        re_L = 1'b1;
  logic        we_L = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        out_ack = 1'b0;
  logic        cpu_drv = 1'b0;
  logic [15:0] cpu_val = 16'h0000;
  wire  [15:0] dataBus;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
`ifdef MMIO_QUEUE_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  assign dataBus = cpu_drv ? cpu_val : 16'bz;

  mmio_queue_port #(.BASE_ADDR(DA), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .memAddr   (memAddr),
    .dataBus   (dataBus),
    .re_L      (re_L),
    .we_L      (we_L),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack)
`ifdef MMIO_QUEUE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: FIFO as a queue plus the output register and sticky flags.
  logic [15:0] m_q[$];
  logic        m_ov = 1'b0;
  logic [15:0] m_od = 16'h0000;
  logic        m_uf = 1'b0;
  logic        m_dr = 1'b0;

  wire m_rd = !re_L && we_L;
  wire m_wr = !we_L;

  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      m_q.delete();
      m_ov <= 1'b0;
      m_od <= 16'h0000;
      m_uf <= 1'b0;
      m_dr <= 1'b0;
    end else begin
      if (m_rd && memAddr == DA && m_q.size() == 0)  m_uf <= 1'b1;
      else if (m_wr && memAddr == SA && cpu_val[11]) m_uf <= 1'b0;
      if (m_wr && memAddr == DA && m_ov && !out_ack)  m_dr <= 1'b1;
      else if (m_wr && memAddr == SA && cpu_val[12]) m_dr <= 1'b0;
      if (m_wr && memAddr == DA && (!m_ov || out_ack)) begin
        m_od <= cpu_val;
        m_ov <= 1'b1;
      end else if (out_ack && m_ov) begin
        m_ov <= 1'b0;
      end
      if (m_rd && memAddr == DA && m_q.size() != 0) begin
        if (in_valid && m_q.size() != DEPTH) m_q.push_back(in_data);
        void'(m_q.pop_front());
      end else if (in_valid && m_q.size() != DEPTH) begin
        m_q.push_back(in_data);
      end
    end
  end

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s      = 16'(m_q.size());
    s[8]   = (m_q.size() == 0);
    s[9]   = (m_q.size() == DEPTH);
    s[10]  = m_ov;
    s[11]  = m_uf;
    s[12]  = m_dr;
    return s;
  endfunction

  function automatic logic [15:0] exp_data();
    return (m_q.size() != 0) ? m_q[0] : 16'h0000;
  endfunction

  task automatic bus_op(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    re_L    = ~r;
    we_L    = ~w;
    memAddr = a;
    cpu_drv = w;
    cpu_val = d;
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0100) $display("FAIL reset_status got %h exp %h", dataBus, 16'h0100); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h exp 0000", out_data); else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clock);
      bus_op(0, 0, 16'h0, 16'h0);
      in_valid = 1'b1;
      in_data  = 16'hA000 + 16'(i);
    end
    @(negedge clock);
    in_data = 16'hA009;
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (dataBus !== 16'h0208) $display("FAIL full_status got %h exp %h", dataBus, 16'h0208); else n_pass++;
    @(negedge clock);
    #1;
    n_checks++; if (dataBus !== 16'h0208) $display("FAIL ninth_push_status got %h exp %h", dataBus, 16'h0208); else n_pass++;
    in_valid = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clock);
      bus_op(1, 0, DA, 16'h0);
      #1;
      n_checks++; if (dataBus !== 16'hA000 + 16'(i)) $display("FAIL drain_%0d got %h exp %h", i, dataBus, 16'hA000 + 16'(i)); else n_pass++;
    end
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0100) $display("FAIL drained_status got %h exp %h", dataBus, 16'h0100); else n_pass++;
  endtask

  task automatic test_underflow();
    @(negedge clock);
    bus_op(1, 0, DA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0000) $display("FAIL empty_read got %h exp 0000", dataBus); else n_pass++;
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0900) $display("FAIL underflow_status got %h exp %h", dataBus, 16'h0900); else n_pass++;
    @(negedge clock);
    bus_op(0, 1, SA, 16'h0800);
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0100) $display("FAIL w1c_status got %h exp %h", dataBus, 16'h0100); else n_pass++;
  endtask

  task automatic test_output();
    @(negedge clock);
    bus_op(0, 1, DA, 16'h1234);
    @(negedge clock);
    bus_op(0, 1, DA, 16'h5678);
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL out_valid_set got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h1234) $display("FAIL out_data_1 got %h exp 1234", out_data); else n_pass++;
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (out_data !== 16'h1234) $display("FAIL out_data_kept got %h exp 1234", out_data); else n_pass++;
    n_checks++; if (dataBus !== 16'h1500) $display("FAIL drop_status got %h exp %h", dataBus, 16'h1500); else n_pass++;
    @(negedge clock);
    bus_op(0, 1, DA, 16'h5678);
    out_ack = 1'b1;
    @(negedge clock);
    bus_op(0, 0, 16'h0, 16'h0);
    #1;
    n_checks++; if (out_data !== 16'h5678) $display("FAIL write_with_ack got %h exp 5678", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL valid_with_ack got %b exp 1", out_valid); else n_pass++;
    @(negedge clock);
    out_ack = 1'b0;
    bus_op(0, 1, SA, 16'h1000);
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0100) $display("FAIL acked_status got %h exp %h", dataBus, 16'h0100); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [15:0] exp_seq [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      bus_op(0, 0, 16'h0, 16'h0);
      in_valid = 1'b1;
      in_data  = 16'hB001 + 16'(i);
      exp_seq[i] = 16'hB002 + 16'(i);
    end
    @(negedge clock);
    in_data = 16'hB009;
    bus_op(1, 0, DA, 16'h0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL pop_full_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (dataBus !== 16'hB001) $display("FAIL pop_full_data got %h exp B001", dataBus); else n_pass++;
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0007) $display("FAIL pop_full_count got %h exp 0007", dataBus); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL refill_ready got %b exp 1", in_ready); else n_pass++;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++; if (dataBus !== 16'h0208) $display("FAIL refill_status got %h exp %h", dataBus, 16'h0208); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      bus_op(1, 0, DA, 16'h0);
      #1;
      n_checks++; if (dataBus !== exp_seq[i]) $display("FAIL wrap_order_%0d got %h exp %h", i, dataBus, exp_seq[i]); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus_op(0, 0, 16'h0, 16'h0);
      in_valid = 1'b1;
      in_data  = 16'hC000 + 16'(i);
    end
    @(negedge clock);
    in_valid = 1'b0;
    bus_op(0, 1, DA, 16'hCAFE);
    @(negedge clock);
    bus_op(1, 0, SA, 16'h0);
    #1;
    n_checks++; if (dataBus !== 16'h0403) $display("FAIL pre_reset_status got %h exp %h", dataBus, 16'h0403); else n_pass++;
    @(posedge clock);
    #2;
    reset_L = 1'b0;
    #1;
    n_checks++; if (dataBus !== 16'h0100) $display("FAIL async_reset_status got %h exp %h", dataBus, 16'h0100); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL async_reset_out_data got %h exp 0000", out_data); else n_pass++;
    @(negedge clock);
    bus_op(0, 0, 16'h0, 16'h0);
    reset_L = 1'b1;
  endtask

`ifdef MMIO_QUEUE_IRQ_EN
  task automatic test_irq();
    @(negedge clock);
    bus_op(0, 1, IA, 16'h0001);
    @(negedge clock);
    bus_op(1, 0, IA, 16'h0);
    in_valid = 1'b1;
    in_data  = 16'hD00D;
    #1;
    n_checks++; if (dataBus !== 16'h0001) $display("FAIL irqen_read got %h exp 0001", dataBus); else n_pass++;
    @(negedge clock);
    in_valid = 1'b0;
    bus_op(0, 0, 16'h0, 16'h0);
    #1;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_lag got %b exp 0", irq); else n_pass++;
    @(negedge clock);
    #1;
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_set got %b exp 1", irq); else n_pass++;
    @(negedge clock);
    bus_op(1, 0, DA, 16'h0);
    @(negedge clock);
    bus_op(0, 1, IA, 16'h0000);
    @(negedge clock);
    bus_op(0, 0, 16'h0, 16'h0);
  endtask
`endif

  task automatic test_random();
    int          op;
    logic [15:0] wd;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      op = int'($urandom_range(0, 5));
      wd = 16'($urandom);
      case (op)
        1:       bus_op(1, 0, DA, 16'h0);
        2:       bus_op(1, 0, SA, 16'h0);
        3:       bus_op(0, 1, DA, wd);
        4:       bus_op(0, 1, SA, wd);
        5: begin bus_op(0, 1, DA, wd); re_L = 1'b0; end
        default: bus_op(0, 0, 16'h0, 16'h0);
      endcase
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 16'($urandom);
      out_ack  = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++; if (in_ready !== (m_q.size() != DEPTH)) $display("FAIL rnd_in_ready cycle %0d got %b exp %b", i, in_ready, m_q.size() != DEPTH); else n_pass++;
      n_checks++; if (out_valid !== m_ov) $display("FAIL rnd_out_valid cycle %0d got %b exp %b", i, out_valid, m_ov); else n_pass++;
      n_checks++; if (out_data !== m_od) $display("FAIL rnd_out_data cycle %0d got %h exp %h", i, out_data, m_od); else n_pass++;
      if (op == 1) begin
        n_checks++; if (dataBus !== exp_data()) $display("FAIL rnd_data cycle %0d got %h exp %h", i, dataBus, exp_data()); else n_pass++;
      end else if (op == 2) begin
        n_checks++; if (dataBus !== exp_status()) $display("FAIL rnd_status cycle %0d got %h exp %h", i, dataBus, exp_status()); else n_pass++;
      end
    end
    @(negedge clock);
    bus_op(0, 0, 16'h0, 16'h0);
    in_valid = 1'b0;
    out_ack  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_output();
    test_full_pop();
    test_async_reset();
`ifdef MMIO_QUEUE_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
